// File: rtl/pipe_add_sub_if.sv
// Handshake/data bundle for pipe_add_sub. Optional zero/neg flags exist only
// when PIPE_ADD_SUB_FLAGS_EN is defined.
interface pipe_add_sub_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef PIPE_ADD_SUB_FLAGS_EN
   logic             zero;
   logic             neg;

   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf, zero, neg);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf, zero, neg);
`else
   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/pipe_add_sub.sv
// Skewed carry-chained add/sub: one CHUNK-bit ripple segment per stage, latency WIDTH/CHUNK.
// Define PIPE_ADD_SUB_FLAGS_EN to add registered zero/neg result flags.
module pipe_add_sub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic          clk,
   input  logic          rst,
   pipe_add_sub_if.slave bus
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam logic [WIDTH-1:0] CH_MASK = WIDTH'({CHUNK{1'b1}});

   logic             w_adv;
   logic [WIDTH-1:0] w_a_in [STAGES];
   logic [WIDTH-1:0] w_b_in [STAGES];
   logic [WIDTH-1:0] w_s_in [STAGES];
   logic [WIDTH-1:0] w_s_nx [STAGES];
   logic [STAGES-1:0] w_v_in, w_c_in, w_c_nx;
   logic             w_ovf_nx;

   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic [STAGES-1:0] r_vld, r_c;
   logic             r_ovf;

   // Whole pipe moves together; it only stalls when the output beat is stuck.
   assign w_adv        = !r_vld[STAGES-1] || bus.out_ready;
   assign bus.in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic [CHUNK-1:0] w_ac, w_bc, w_ch;
      logic             w_co;

      if (k == 0) begin : g_head
         assign w_v_in[k] = bus.in_valid;
         assign w_a_in[k] = bus.a;
         assign w_b_in[k] = bus.sub ? ~bus.b : bus.b;
         assign w_c_in[k] = bus.sub ^ bus.cin;
         assign w_s_in[k] = '0;
      end else begin : g_body
         assign w_v_in[k] = r_vld[k-1];
         assign w_a_in[k] = r_a[k-1];
         assign w_b_in[k] = r_b[k-1];
         assign w_c_in[k] = r_c[k-1];
         assign w_s_in[k] = r_s[k-1];
      end

      assign w_ac          = w_a_in[k][k*CHUNK +: CHUNK];
      assign w_bc          = w_b_in[k][k*CHUNK +: CHUNK];
      assign {w_co, w_ch}  = {1'b0, w_ac} + {1'b0, w_bc} + {{CHUNK{1'b0}}, w_c_in[k]};
      assign w_c_nx[k]     = w_co;
      assign w_s_nx[k]     = (w_s_in[k] & ~(CH_MASK << (k*CHUNK))) | (WIDTH'(w_ch) << (k*CHUNK));

      if (k == STAGES-1) begin : g_tail
         // a^b^s at the MSB recovers the carry into it
         assign w_ovf_nx = w_ac[CHUNK-1] ^ w_bc[CHUNK-1] ^ w_ch[CHUNK-1] ^ w_co;
      end
   end

`ifdef PIPE_ADD_SUB_FLAGS_EN
   logic r_zero, r_neg;
   assign bus.zero = r_zero;
   assign bus.neg  = r_neg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
`ifdef PIPE_ADD_SUB_FLAGS_EN
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
`endif
      end else if (w_adv) begin
         r_vld <= w_v_in;
         for (int k = 0; k < STAGES; k++) begin
            if (w_v_in[k]) begin
               r_a[k] <= w_a_in[k];
               r_b[k] <= w_b_in[k];
               r_s[k] <= w_s_nx[k];
               r_c[k] <= w_c_nx[k];
            end
         end
         if (w_v_in[STAGES-1]) begin
            r_ovf <= w_ovf_nx;
`ifdef PIPE_ADD_SUB_FLAGS_EN
            r_zero <= (w_s_nx[STAGES-1] == '0);
            r_neg  <= w_s_nx[STAGES-1][WIDTH-1];
`endif
         end
      end
   end

   assign bus.out_valid = r_vld[STAGES-1];
   assign bus.sum       = r_s[STAGES-1];
   assign bus.cout      = r_c[STAGES-1];
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: directed vectors, back-to-back, stall,
// reset flush and random traffic against an arithmetic reference model.
module tb_pipe_add_sub;
   localparam int W  = 32;
   localparam int C  = 8;
   localparam int ST = W / C;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_add_sub_if #(.WIDTH(W)) bus ();
   pipe_add_sub #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   res_t q[$];
   int   nvec = 0;
   int   nerr = 0;

   // Signed/unsigned arithmetic on wide integers, independent of chunking.
   function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
      res_t r;
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint smax = (longint'(1) <<< (W-1)) - 1;
      longint smin = -(longint'(1) <<< (W-1));
      longint s;
      longint unsigned u;
      if (!sub) begin
         u      = ua + ub + 64'(cin);
         r.cout = u[W];
         s      = sa + sb + longint'(cin);
      end else begin
         u      = ua - ub - 64'(cin);
         r.cout = (ua >= ub + 64'(cin));
         s      = sa - sb - longint'(cin);
      end
      r.sum = u[W-1:0];
      r.ovf = (s > smax) || (s < smin);
      return r;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive(logic v, logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub, logic ordy);
      bus.in_valid  = v;
      bus.a         = a;
      bus.b         = b;
      bus.cin       = cin;
      bus.sub       = sub;
      bus.out_ready = ordy;
   endtask

   // Evaluate handshakes at mid-cycle, then let one clock edge pass.
   task automatic tick();
      res_t e;
      #1;
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
               e = q.pop_front();
               chk("result", {bus.sum, bus.cout, bus.ovf}, {e.sum, e.cout, e.ovf});
`ifdef PIPE_ADD_SUB_FLAGS_EN
               chk("flags", {bus.zero, bus.neg}, {(e.sum == '0), e.sum[W-1]});
`endif
            end
         end
         if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic single(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub,
                         logic [W-1:0] es, logic ec, logic eo);
      int n = 0;
      drive(1, a, b, cin, sub, 1);
      tick();
      drive(0, '0, '0, 0, 0, 1);
      while (!bus.out_valid && n < 20) begin tick(); n++; end
      chk("latency", 64'(n), 64'(ST-1));
      chk("tp_result", {bus.sum, bus.cout, bus.ovf}, {es, ec, eo});
      tick();
   endtask

   initial begin
      res_t snap;
      int   first, cnt, n;
      rst = 1'b1;
      drive(0, '0, '0, 0, 0, 0);
      @(negedge clk);
      tick();
      tick();
      chk("rst_state", {bus.out_valid, bus.sum, bus.cout, bus.ovf}, '0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1 chk("rst_in_ready", bus.in_ready, 1);

      single(32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0000_0000, 1, 0);
      single(32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
      single(32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0);
      single(32'd7, 32'd5, 0, 1, 32'h0000_0002, 1, 0);

      // back-to-back stream
      first = -1; cnt = 0;
      for (int t = 0; t < 8 + ST + 2; t++) begin
         if (t < 8) drive(1, W'(t), W'(t + 1), 0, 0, 1);
         else       drive(0, '0, '0, 0, 0, 1);
         #1;
         if (bus.out_valid) begin
            if (first < 0) first = t;
            chk("b2b_sum", bus.sum, 64'(2*cnt + 1));
            chk("b2b_contig", 64'(t), 64'(first + cnt));
            cnt++;
         end
         tick();
      end
      chk("b2b_count", 64'(cnt), 8);

      // fill, stall three cycles with a held beat, then drain
      for (int t = 0; t < ST; t++) begin
         drive(1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1);
         tick();
      end
      drive(1, 32'h1234_5678, 32'h0FED_CBA9, 0, 1, 0);
      #1 snap = {bus.sum, bus.cout, bus.ovf};
      chk("stall_valid", bus.out_valid, 1);
      for (int t = 0; t < 3; t++) begin
         chk("stall_in_ready", bus.in_ready, 0);
         tick();
         chk("stall_frozen", {bus.out_valid, bus.sum, bus.cout, bus.ovf}, {1'b1, snap});
      end
      bus.out_ready = 1'b1;
      tick();
      drive(0, '0, '0, 0, 0, 1);
      n = 0;
      while (q.size() != 0 && n < 50) begin tick(); n++; end
      chk("stall_drain_empty", 64'(q.size()), 0);

      // random traffic
      for (int t = 0; t < 400; t++) begin
         drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
         if (t % 50 == 0) bus.a = 32'hFFFF_FFFF;
         tick();
      end
      drive(0, '0, '0, 0, 0, 1);
      n = 0;
      while (q.size() != 0 && n < 50) begin tick(); n++; end
      chk("rand_drain_empty", 64'(q.size()), 0);

      // reset with beats in flight
      for (int t = 0; t < 3; t++) begin
         drive(1, W'($urandom), W'($urandom), 0, 0, 1);
         tick();
      end
      drive(0, '0, '0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      chk("flush_state", {bus.out_valid, bus.sum, bus.cout, bus.ovf}, '0);
`ifdef PIPE_ADD_SUB_FLAGS_EN
      chk("flush_flags", {bus.zero, bus.neg}, '0);
`endif
      bus.out_ready = 1'b1;
      for (int t = 0; t < ST + 4; t++) begin
         chk("flush_no_stale", bus.out_valid, 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
